lcd_chess_display: RTL

- Parametrised character-LCD sequencer for the two-player clock (HD44780-style, 8-bit bus).
- Sits between the timer digit outputs and the LCD pins. Replaces the single-line refresh with:
  - a timed power-up/init sequence;
  - a two-line display (player A on line 1, player B on line 2) with an active-player marker;
  - a configurable digit count and a refresh mode.
- Digits are snapshotted per frame so a line never shows a torn value.

---
 rtl/lcd_chess_display_if.sv | 22 ++
 rtl/lcd_chess_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_chess_display_if.sv
// LCD pin bundle and sequencer status for the chess-clock display.
// The sequencer drives it (master); the panel/bench observes it (slave).
interface lcd_chess_display_if;
   logic [8:0] lcd_data;
   logic       lcd_en;
   logic       busy;
   logic       frame_done;

   modport master (
      output lcd_data,
      output lcd_en,
      output busy,
      output frame_done
   );

   modport slave (
      input lcd_data,
      input lcd_en,
      input busy,
      input frame_done
   );
endinterface

// File: rtl/lcd_chess_display.sv
// HD44780 8-bit sequencer: timed init, then two-line frames
// (player A / player B) built from per-frame digit snapshots.
module lcd_chess_display #(
   parameter int TICK_DIV    = 50000,
   parameter int EN_HIGH     = 25,
   parameter int DIGITS      = 4,
   parameter int INIT_WAIT   = 20,
   parameter int CLEAR_SLOTS = 2,
   parameter bit AUTO        = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                jugador,
   input  logic [4*DIGITS-1:0] digits_a,
   input  logic [4*DIGITS-1:0] digits_b,
   input  logic                refresh,
   lcd_chess_display_if.master lcd
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int NW = DIGITS + 5;

   typedef enum logic [2:0] {
      S_WAIT,
      S_INIT,
      S_IDLE,
      S_LINE1,
      S_LINE2
   } state_t;

   state_t              r_state;
   logic [TW-1:0]       r_tick;
   logic [15:0]         r_cnt;
   logic [3:0]          r_idx;
   logic                r_wr;
   logic [8:0]          r_data;
   logic                r_en;
   logic                r_busy;
   logic                r_done;
   logic                r_pend;
   logic [4*DIGITS-1:0] r_snap_a;
   logic [4*DIGITS-1:0] r_snap_b;
   logic                r_snap_j;

   logic                w_bnd;
   logic                w_start;
   logic [8:0]          w_cmd;
   logic [8:0]          w_char;
   logic [4*DIGITS-1:0] w_dsel;
   logic                w_line2;
   logic                w_mark;
   logic                w_colon;
   logic [3:0]          w_pos;
   logic [3:0]          w_dig;
   logic [3:0]          w_rev;
   logic [3:0]          w_nib;

   assign w_bnd   = (r_tick == TW'(TICK_DIV - 1));
   assign w_start = AUTO || r_pend || refresh;

   // Init command table, indexed by the next command to issue.
   always_comb begin
      w_cmd = 9'h001;
      unique case (r_idx)
         4'd0:    w_cmd = 9'h038;
         4'd1:    w_cmd = 9'h00C;
         4'd2:    w_cmd = 9'h006;
         default: w_cmd = 9'h001;
      endcase
   end

   // Character for line position r_idx, taken from the frame snapshot.
   always_comb begin
      w_line2 = (r_state == S_LINE2);
      w_dsel  = w_line2 ? r_snap_b : r_snap_a;
      w_mark  = w_line2 ? r_snap_j : !r_snap_j;
      w_pos   = r_idx - 4'd4;
      w_colon = (r_idx == 4'(DIGITS + 2));
      w_dig   = (w_pos < 4'(DIGITS - 2)) ? w_pos : w_pos - 4'd1;
      w_rev   = 4'(DIGITS - 1) - w_dig;
      w_nib   = 4'h0;
      for (int k = 0; k < DIGITS; k++)
         if (w_rev == 4'(k))
            w_nib = w_dsel[4*k +: 4];
      w_char = 9'h120;
      unique case (1'b1)
         (r_idx == 4'd0): w_char = w_line2 ? 9'h0C0 : 9'h080;
         (r_idx == 4'd1): w_char = w_line2 ? 9'h142 : 9'h141;
         (r_idx == 4'd2): w_char = w_mark ? 9'h12A : 9'h120;
         (r_idx == 4'd3): w_char = 9'h120;
         w_colon:         w_char = 9'h13A;
         default:         w_char = (w_nib <= 4'd9) ? {5'b1_0011, w_nib} : 9'h12D;
      endcase
   end

   // Slot timer, enable strobe and the init/frame sequencer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_WAIT;
         r_tick   <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_wr     <= 1'b0;
         r_data   <= 9'h000;
         r_en     <= 1'b0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
         r_pend   <= 1'b0;
         r_snap_a <= '0;
         r_snap_b <= '0;
         r_snap_j <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_tick <= w_bnd ? '0 : r_tick + TW'(1);
         r_en   <= r_wr && !w_bnd && (r_tick < TW'(EN_HIGH));
         if (refresh && !AUTO)
            r_pend <= 1'b1;
         if (w_bnd) begin
            r_wr <= 1'b0;
            unique case (r_state)
               S_WAIT: begin
                  if (r_cnt + 16'd1 >= 16'(INIT_WAIT)) begin
                     r_data  <= w_cmd;
                     r_wr    <= 1'b1;
                     r_idx   <= 4'd1;
                     r_cnt   <= '0;
                     r_state <= S_INIT;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               S_INIT: begin
                  if (r_idx != 4'd4) begin
                     r_data <= w_cmd;
                     r_wr   <= 1'b1;
                     r_idx  <= r_idx + 4'd1;
                  end else if (r_cnt == 16'(CLEAR_SLOTS)) begin
                     r_cnt   <= '0;
                     r_idx   <= '0;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               S_IDLE: begin
                  if (w_start) begin
                     r_snap_a <= digits_a;
                     r_snap_b <= digits_b;
                     r_snap_j <= jugador;
                     r_pend   <= 1'b0;
                     r_busy   <= 1'b1;
                     r_data   <= 9'h080;
                     r_wr     <= 1'b1;
                     r_idx    <= 4'd1;
                     r_state  <= S_LINE1;
                  end
               end
               S_LINE1: begin
                  r_wr <= 1'b1;
                  if (r_idx != 4'(NW)) begin
                     r_data <= w_char;
                     r_idx  <= r_idx + 4'd1;
                  end else begin
                     r_data  <= 9'h0C0;
                     r_idx   <= 4'd1;
                     r_state <= S_LINE2;
                  end
               end
               S_LINE2: begin
                  if (r_idx != 4'(NW)) begin
                     r_data <= w_char;
                     r_wr   <= 1'b1;
                     r_idx  <= r_idx + 4'd1;
                  end else begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_idx   <= '0;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_WAIT;
            endcase
         end
      end
   end

   assign lcd.lcd_data   = r_data;
   assign lcd.lcd_en     = r_en;
   assign lcd.busy       = r_busy;
   assign lcd.frame_done = r_done;

endmodule
